// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: control levels,
// bus widths and the fetch FSM state type.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic              RST_ENA   = 1'b1;
  localparam logic              STOP      = 1'b1;
  localparam logic              NO_STOP   = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_FETCH = 2'b01,
    IF_HOLD  = 2'b10,
    IF_DRAIN = 2'b11
  } if_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over req/ack and
// presents them to IF/ID, applying delayed branches and exception flushes.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   inst_req,
  output logic [INST_ADDR_W-1:0] inst_addr,
  input  logic                   inst_ack,
  input  logic [INST_W-1:0]      inst_rdata,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   stallreq_if
);

  if_state_t              state, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0]      inst_q, inst_d;
  logic                   brk_pend, brk_pend_d;
  logic [INST_ADDR_W-1:0] brk_tgt, brk_tgt_d;
  logic [INST_ADDR_W-1:0] redir_q, redir_d;
  logic [INST_ADDR_W-1:0] next_pc;
  logic                   consume;
  logic                   unused_stall;

  assign unused_stall = ^stall[5:1];

  assign consume = (state == IF_HOLD) && (stall[0] == NO_STOP) && !flush;
  assign next_pc = branch_flag_i ? branch_target_i :
                   brk_pend      ? brk_tgt         : pc_q + 32'd4;

  always_comb begin
    state_d    = state;
    pc_d       = pc_q;
    inst_d     = inst_q;
    brk_pend_d = brk_pend;
    brk_tgt_d  = brk_tgt;
    redir_d    = redir_q;

    // A branch seen outside the consume cycle waits for the delay slot.
    if (flush) begin
      brk_pend_d = 1'b0;
    end else if (branch_flag_i && !consume) begin
      brk_pend_d = 1'b1;
      brk_tgt_d  = branch_target_i;
    end

    unique case (state)
      IF_IDLE: begin
        state_d = IF_FETCH;
        if (flush) pc_d = new_pc;
      end
      IF_FETCH: begin
        if (inst_ack) begin
          if (flush) begin
            pc_d = new_pc;
          end else begin
            inst_d  = inst_rdata;
            state_d = IF_HOLD;
          end
        end else if (flush) begin
          redir_d = new_pc;
          state_d = IF_DRAIN;
        end
      end
      IF_DRAIN: begin
        // The outstanding request must complete before redirecting.
        if (flush) redir_d = new_pc;
        if (inst_ack) begin
          pc_d    = flush ? new_pc : redir_q;
          state_d = IF_FETCH;
        end
      end
      IF_HOLD: begin
        if (flush) begin
          pc_d    = new_pc;
          state_d = IF_FETCH;
        end else if (consume) begin
          pc_d       = next_pc;
          brk_pend_d = 1'b0;
          state_d    = IF_FETCH;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENA) begin
      state    <= IF_IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      brk_pend <= 1'b0;
      brk_tgt  <= '0;
      redir_q  <= '0;
    end else begin
      state    <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      brk_pend <= brk_pend_d;
      brk_tgt  <= brk_tgt_d;
      redir_q  <= redir_d;
    end
  end

  assign inst_req    = (state == IF_FETCH) || (state == IF_DRAIN);
  assign inst_addr   = pc_q;
  assign if_pc       = pc_q;
  assign if_inst     = (state == IF_HOLD) ? inst_q : ZERO_WORD;
  assign stallreq_if = (state != IF_HOLD);

endmodule

// File: tb/tb_if_fetch.sv
// Directed and random stimulus for if_fetch, checked cycle by cycle against
// a flag-based transaction model of the fetch stage.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int errors = 0;
  int checks = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .stallreq_if(stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: boot = one idle cycle after reset, busy = request outstanding,
  // discard = outstanding data will be thrown away, have = word presented.
  bit          m_boot, m_busy, m_discard, m_have, m_pend;
  logic [31:0] m_pc, m_inst, m_tgt, m_redir;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]} + 32'h0001_3579;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rs, input logic s0, input logic fl,
                      input logic [31:0] np, input logic br,
                      input logic [31:0] bt, input logic ak);
    bit consumed;
    logic [31:0] rd;
    rd = ak ? memw(m_pc) : $urandom();
    rst = rs; stall = {5'($urandom_range(31)), s0}; flush = fl; new_pc = np;
    branch_flag_i = br; branch_target_i = bt; inst_ack = ak; inst_rdata = rd;
    @(posedge clk);
    consumed = 0;
    if (rs) begin
      m_boot = 1; m_busy = 0; m_discard = 0; m_have = 0; m_pend = 0;
      m_pc = 32'h0; m_inst = 32'h0; m_redir = 32'h0;
    end else begin
      if (m_boot) begin
        m_boot = 0; m_busy = 1;
        if (fl) m_pc = np;
      end else if (m_have) begin
        if (fl) begin
          m_pc = np; m_have = 0; m_busy = 1;
        end else if (!s0) begin
          m_pc = br ? bt : (m_pend ? m_tgt : m_pc + 32'd4);
          m_have = 0; m_busy = 1; consumed = 1;
        end
      end else if (ak) begin
        if (m_discard) begin
          m_pc = fl ? np : m_redir; m_discard = 0;
        end else if (fl) begin
          m_pc = np;
        end else begin
          m_inst = rd; m_have = 1; m_busy = 0;
        end
      end else if (fl) begin
        m_discard = 1; m_redir = np;
      end
      if (fl || consumed) m_pend = 0;
      else if (br) begin m_pend = 1; m_tgt = bt; end
    end
    #1;
    chk("inst_req", {31'b0, inst_req}, {31'b0, m_busy});
    chk("inst_addr", inst_addr, m_pc);
    chk("if_pc", if_pc, m_pc);
    chk("if_inst", if_inst, m_have ? m_inst : 32'h0);
    chk("stallreq_if", {31'b0, stallreq_if}, {31'b0, !m_have});
  endtask

  // Shorthand: plain cycle with stall[0], no flush/branch.
  task automatic go(input logic s0, input logic ak);
    step(1'b0, s0, 1'b0, 32'h0, 1'b0, 32'h0, ak);
  endtask

  initial begin
    // 1. reset then zero-wait sequential fetches 0,4,8,C
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("rst_req", {31'b0, inst_req}, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq_if}, 32'h1);
    go(1'b0, 1'b1);
    chk("first_addr", inst_addr, 32'h0);
    for (int i = 0; i < 8; i++) go(1'b0, 1'b1);
    chk("seq_addr_10", inst_addr, 32'h10);
    // 2. three wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 1'b0);
      chk("wait_addr", inst_addr, 32'h10);
    end
    go(1'b0, 1'b1);
    chk("wait_inst", if_inst, memw(32'h10));
    // 3. advance to HOLD 0x20, stall two cycles, release
    for (int i = 0; i < 8; i++) go(1'b0, 1'b1);
    chk("hold_pc_20", if_pc, 32'h20);
    go(1'b1, 1'b1);
    go(1'b1, 1'b0);
    chk("stall_pc", if_pc, 32'h20);
    chk("stall_inst", if_inst, memw(32'h20));
    go(1'b0, 1'b1);
    chk("after_stall_addr", inst_addr, 32'h24);
    // 4. delayed branch: consume-cycle branch to 0x40, then pending to 0x100
    go(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
    chk("br_consume_addr", inst_addr, 32'h40);
    go(1'b0, 1'b1);
    go(1'b0, 1'b0);
    chk("slot_addr", inst_addr, 32'h44);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    go(1'b0, 1'b1);
    chk("slot_presented", if_pc, 32'h44);
    go(1'b0, 1'b1);
    chk("br_target_addr", inst_addr, 32'h100);
    go(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    go(1'b0, 1'b1);
    chk("br_overwrite_addr", inst_addr, 32'h200);
    // 5. flush mid-fetch at 0x48 with a pending branch
    go(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    go(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0);
    chk("drain_addr", inst_addr, 32'h48);
    go(1'b0, 1'b0);
    chk("drain_addr2", inst_addr, 32'h48);
    go(1'b0, 1'b1);
    chk("drain_inst", if_inst, 32'h0);
    chk("redir_addr", inst_addr, 32'h180);
    go(1'b0, 1'b1);
    go(1'b0, 1'b1);
    chk("pend_cleared", inst_addr, 32'h184);
    // 6. wrap at top of address space, flush in HOLD under stall
    go(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    go(1'b0, 1'b1);
    go(1'b0, 1'b1);
    chk("wrap_addr", inst_addr, 32'h0);
    go(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    chk("hold_flush_addr", inst_addr, 32'h8);
    // random phase, including reset mid-fetch
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(49) == 0), 1'($urandom_range(1)),
           ($urandom_range(7) == 0), {$urandom_range(32'h3FFF), 2'b00},
           ($urandom_range(5) == 0), {$urandom_range(32'h3FFF), 2'b00},
           1'($urandom_range(1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
